card_dealer: RTL and testbench
==============================

// Module: card_dealer
// PURPOSE
// - Card source (responder) for the blackjack game FSM. Holds a 52-card shoe,
//   shuffles it with an LFSR-driven Fisher-Yates pass, and returns one card per
//   accepted draw request through a req/ready -> valid handshake.
// - Sits between the game FSM (initiator) and the score datapath. Replaces free-running card generation.
// PARAMETERS
// - LFSR_SEED   16'hACE1  initial LFSR state; a value of 0 is forced to 16'h0001
// - FACE_VALUE  4'd10     value reported for ranks 11..13 (J, Q, K)
// - ACE_VALUE   4'd1      value reported for rank 1
// PORTS
// - clk          in   1  clock, rising edge
// - reset        in   1  reset, asynchronous, active-high
// - draw_req     in   1  request one card; accepted on a cycle where draw_req & draw_ready
// - draw_ready   out  1  = (state==IDLE) & (cards_left!=0) & !shuffle_req (combinational)
// - card_valid   out  1  one-cycle pulse; card_value/card_rank valid
// - card_value   out  4  blackjack value: ACE_VALUE, 2..10, or FACE_VALUE
// - card_rank    out  4  raw rank 1..13
// - cards_left   out  6  undealt cards in shoe, 0..52
// - shuffle_req  in   1  force reshuffle of full shoe (sampled in IDLE only)
// - shuffling    out  1  high in FILL/SHUF states
// BEHAVIOUR
// - Reset values: state=FILL, fill/ptr index 0, cards_left=0, card_valid=0,
//   card_value=0, card_rank=0, shuffling=1, lfsr=LFSR_SEED (0 forced to 1).
// - Shoe storage: deck[0..51] x 4 bits. LFSR: 16-bit Galois, taps 16,14,13,11.
//   Advances every cycle; it is not reloaded on reshuffle, so each shoe differs.
// - FILL: writes deck[k]=(k%13)+1 for k=0..51, one entry/cycle (52 cycles).
//   At k=51 -> SHUF with i=51.
// - SHUF: r=lfsr[5:0]. If r<=i: swap deck[i]<->deck[r], i<=i-1. Else retry next cycle.
//   When a swap with i==1 completes -> IDLE; cards_left<=52, ptr<=0.
// - IDLE: shuffle_req=1 -> FILL, and no draw is accepted that cycle
//   (shuffle_req has priority). Otherwise, on draw accept at edge N: card_rank<=deck[ptr],
//   card_value<=map(deck[ptr]), card_valid<=1 for one cycle, ptr<=ptr+1, cards_left<=cards_left-1.
// - Latency: accept at edge N -> card_valid high for cycle N+1. Back-to-back accepts
//   give card_valid on consecutive cycles (throughput 1 card/cycle).
// - card_value/card_rank hold the last card until the next deal. card_valid=0 otherwise.
// - Empty shoe: the accept that takes cards_left 1->0 also moves state to FILL (auto reshuffle).
//   draw_ready is low until SHUF completes. Requests while not ready are dropped, not queued.
// - shuffle_req outside IDLE: ignored. draw_req during FILL/SHUF: ignored.
// - Reset mid-operation (any state): immediate return to reset values. The in-progress
//   shuffle is discarded and restarts from FILL. card_valid is never emitted for an interrupted deal.
// - Value map: 1->ACE_VALUE, 2..10->rank, 11..13->FACE_VALUE. No arithmetic overflow:
//   cards_left 6 bits covers 0..52, indices 6 bits.
// CONFIGURATION
// - DEALER_FIXED_DECK_EN defined: SHUF state is compiled out. FILL -> IDLE directly after 52 cycles.
//   The shoe is dealt in fill order (ranks 1,2,...,13,1,2,...), giving a deterministic sequence for benches.
// - DEALER_FIXED_DECK_EN undefined (default): LFSR shuffle as above.
// TESTING
// - FIXED_DECK_EN, reset release -> draw_ready=1 after exactly 52 cycles, cards_left=52.
//   13 draws -> card_value 1,2..10,10,10,10 and card_rank 1..13.
// - FIXED_DECK_EN, draw_req held 52 cycles -> 52 consecutive card_valid pulses.
//   cards_left counts down to 0, then shuffling=1 and draw_ready=0.
//   52 cycles later cards_left=52 again.
// - Default build, deal full shoe -> each rank 1..13 seen exactly 4 times.
//   Sequence differs from a second shoe after reshuffle.
// - IDLE, shuffle_req=1 and draw_req=1 same cycle -> no card_valid, cards_left=0 next cycle, shuffling=1.
// - Reset asserted mid-SHUF, then released -> outputs at reset values, restart from FILL,
//   valid full shoe (4 of each rank) afterwards.
// - draw_req while shuffling=1 -> no card_valid, cards_left unchanged after shuffle completes (52).

Source files
------------

// File: rtl/card_dealer.sv
// card_dealer: 52-card shoe, LFSR-driven Fisher-Yates shuffle, one card per accepted draw.
// Optional macro DEALER_FIXED_DECK_EN compiles out the shuffle; the shoe is dealt in fill order.
module card_dealer #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [3:0]  FACE_VALUE = 4'd10,
  parameter logic [3:0]  ACE_VALUE  = 4'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       draw_req,
  output logic       draw_ready,
  output logic       card_valid,
  output logic [3:0] card_value,
  output logic [3:0] card_rank,
  output logic [5:0] cards_left,
  input  logic       shuffle_req,
  output logic       shuffling
);

  localparam int unsigned DECK_N  = 52;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned RANK_W  = 4;
  localparam int unsigned RANK_N  = 13;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DECK_N - 1);
  localparam logic [IDX_W-1:0] FULL_CNT = IDX_W'(DECK_N);

`ifdef DEALER_FIXED_DECK_EN
  typedef enum logic [1:0] {S_FILL, S_IDLE} state_t;
`else
  typedef enum logic [1:0] {S_FILL, S_SHUF, S_IDLE} state_t;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic [RANK_W-1:0]   r_deck [DECK_N];
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_cards_left;
  logic [RANK_W-1:0]   r_fill_rank;
  logic                r_card_valid;
  logic [RANK_W-1:0]   r_card_value;
  logic [RANK_W-1:0]   r_card_rank;
  logic                r_shuffling;
  logic [RANK_W-1:0]   w_top;
  logic                w_fill_we;
  logic                w_shoe_ready;
  logic                w_deal;
  logic                w_restart;

  function automatic logic [RANK_W-1:0] f_value(input logic [RANK_W-1:0] rank);
    if (rank == RANK_W'(1))        return ACE_VALUE;
    else if (rank >= RANK_W'(11))  return FACE_VALUE;
    else                           return rank;
  endfunction

`ifndef DEALER_FIXED_DECK_EN
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] TAPS     = 16'hB400;
  logic [15:0]       r_lfsr;
  logic [IDX_W-1:0]  w_r;
  logic              w_swap;

  // Free-running Galois LFSR; never reloaded so successive shoes differ
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= SEED_EFF;
    else       r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? TAPS : 16'h0000);
  end
  assign w_r = r_lfsr[IDX_W-1:0];
`endif

  assign w_top      = r_deck[r_ptr];
  assign draw_ready = (r_state == S_IDLE) && (r_cards_left != '0) && !shuffle_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FILL;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_fill_we    = 1'b0;
    w_shoe_ready = 1'b0;
    w_deal       = 1'b0;
    w_restart    = 1'b0;
`ifndef DEALER_FIXED_DECK_EN
    w_swap       = 1'b0;
`endif
    case (r_state)
      S_FILL: begin
        w_fill_we = 1'b1;
        if (r_idx == LAST_IDX) begin
`ifdef DEALER_FIXED_DECK_EN
          w_state_nxt  = S_IDLE;
          w_shoe_ready = 1'b1;
`else
          w_state_nxt  = S_SHUF;
`endif
        end
      end
`ifndef DEALER_FIXED_DECK_EN
      // Rejection sampling: draws outside 0..i are retried on the next LFSR value
      S_SHUF: begin
        if (w_r <= r_idx) begin
          w_swap = 1'b1;
          if (r_idx == IDX_W'(1)) begin
            w_state_nxt  = S_IDLE;
            w_shoe_ready = 1'b1;
          end
        end
      end
`endif
      S_IDLE: begin
        if (shuffle_req) begin
          w_state_nxt = S_FILL;
          w_restart   = 1'b1;
        end else if (draw_req && (r_cards_left != '0)) begin
          w_deal = 1'b1;
          if (r_cards_left == IDX_W'(1)) begin
            w_state_nxt = S_FILL;
            w_restart   = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_ptr        <= '0;
      r_cards_left <= '0;
      r_fill_rank  <= RANK_W'(1);
      r_card_valid <= 1'b0;
      r_card_value <= '0;
      r_card_rank  <= '0;
      r_shuffling  <= 1'b1;
    end else begin
      r_card_valid <= w_deal;
      r_shuffling  <= (w_state_nxt != S_IDLE);
      if (w_fill_we) begin
        r_fill_rank <= (r_fill_rank == RANK_W'(RANK_N)) ? RANK_W'(1) : r_fill_rank + RANK_W'(1);
        r_idx       <= (r_idx == LAST_IDX) ? LAST_IDX : r_idx + IDX_W'(1);
      end
`ifndef DEALER_FIXED_DECK_EN
      if (w_swap) r_idx <= r_idx - IDX_W'(1);
`endif
      if (w_shoe_ready) begin
        r_cards_left <= FULL_CNT;
        r_ptr        <= '0;
      end
      if (w_deal) begin
        r_card_rank  <= w_top;
        r_card_value <= f_value(w_top);
        r_ptr        <= r_ptr + IDX_W'(1);
        r_cards_left <= r_cards_left - IDX_W'(1);
      end
      if (w_restart) begin
        r_idx        <= '0;
        r_fill_rank  <= RANK_W'(1);
        r_cards_left <= '0;
      end
    end
  end

  // Shoe storage needs no reset: FILL rewrites every entry before any deal
  always_ff @(posedge clk) begin
    if (w_fill_we) r_deck[r_idx] <= r_fill_rank;
`ifndef DEALER_FIXED_DECK_EN
    if (w_swap) begin
      r_deck[r_idx] <= r_deck[w_r];
      r_deck[w_r]   <= r_deck[r_idx];
    end
`endif
  end

  assign card_valid = r_card_valid;
  assign card_value = r_card_value;
  assign card_rank  = r_card_rank;
  assign cards_left = r_cards_left;
  assign shuffling  = r_shuffling;

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: shoe-level reference model plus directed scenarios.
module tb_card_dealer;

  localparam int N = 52;

  logic       clk = 1'b0;
  logic       reset;
  logic       draw_req;
  logic       shuffle_req;
  logic       draw_ready;
  logic       card_valid;
  logic [3:0] card_value;
  logic [3:0] card_rank;
  logic [5:0] cards_left;
  logic       shuffling;

  always #5 clk = ~clk;

  card_dealer dut (
    .clk         (clk),
    .reset       (reset),
    .draw_req    (draw_req),
    .draw_ready  (draw_ready),
    .card_valid  (card_valid),
    .card_value  (card_value),
    .card_rank   (card_rank),
    .cards_left  (cards_left),
    .shuffle_req (shuffle_req),
    .shuffling   (shuffling)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: whole shoe computed at once when a fill starts
  logic [3:0]  m_deck [N];
  int          m_busy_left = 0;
  int          m_left = 0;
  int          m_ptr = 0;
  logic        m_valid = 1'b0;
  logic [3:0]  m_rank = 4'd0;
  logic [15:0] m_lfsr = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [3:0] exp_value(input logic [3:0] rank);
    case (rank)
      4'd1:               return 4'd1;
      4'd11, 4'd12, 4'd13: return 4'd10;
      default:            return rank;
    endcase
  endfunction

  task automatic start_fill();
    logic [15:0] l;
    logic [3:0]  t;
    int i, r, n;
    for (int k = 0; k < N; k++) m_deck[k] = 4'((k % 13) + 1);
    m_left = 0;
    n = 0;
`ifndef DEALER_FIXED_DECK_EN
    l = m_lfsr;
    repeat (52) l = lfsr_step(l);
    i = 51;
    while (i >= 1 && n < 100000) begin
      r = int'(l[5:0]);
      if (r <= i) begin
        t = m_deck[i]; m_deck[i] = m_deck[r]; m_deck[r] = t;
        i--;
      end
      l = lfsr_step(l);
      n++;
    end
`endif
    m_busy_left = 52 + n;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr  = 16'hACE1;
      m_valid = 1'b0;
      m_rank  = 4'd0;
      m_ptr   = 0;
      start_fill();
    end else begin
      m_lfsr  = lfsr_step(m_lfsr);
      m_valid = 1'b0;
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          m_left = 52;
          m_ptr  = 0;
        end
      end else if (shuffle_req) begin
        start_fill();
      end else if (draw_req && m_left > 0) begin
        m_valid = 1'b1;
        m_rank  = m_deck[m_ptr];
        m_ptr++;
        m_left--;
        if (m_left == 0) start_fill();
      end
    end
  end

  logic [3:0] q[$];
  logic [3:0] qv[$];

  // Per-cycle compare against the model, and card collection
  always @(negedge clk) begin
    chk("draw_ready", int'(draw_ready), int'(m_busy_left == 0 && m_left > 0 && !shuffle_req));
    chk("shuffling",  int'(shuffling),  int'(m_busy_left > 0));
    chk("cards_left", int'(cards_left), m_left);
    chk("card_valid", int'(card_valid), int'(m_valid));
    chk("card_rank",  int'(card_rank),  int'(m_rank));
    chk("card_value", int'(card_value), int'(exp_value(m_rank)));
    if (card_valid) begin
      q.push_back(card_rank);
      qv.push_back(card_value);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      seen = draw_ready;
    end
    chk({tag, "_ready_timeout"}, int'(seen), 1);
  endtask

  task automatic check_hist(input string tag);
    int cnt [14];
    foreach (cnt[r]) cnt[r] = 0;
    foreach (q[k]) if (q[k] >= 4'd1 && q[k] <= 4'd13) cnt[int'(q[k])]++;
    chk({tag, "_cards"}, q.size(), 52);
    for (int r = 1; r <= 13; r++) chk($sformatf("%s_rank%0d_count", tag, r), cnt[r], 4);
  endtask

  task automatic deal_full_shoe(input string tag);
    q.delete(); qv.delete();
    tick(); draw_req = 1'b1;
    repeat (52) tick();
    draw_req = 1'b0;
    tick();
    @(negedge clk);
    chk({tag, "_left_empty"}, int'(cards_left), 0);
    chk({tag, "_shuffling"},  int'(shuffling), 1);
    chk({tag, "_not_ready"},  int'(draw_ready), 0);
    check_hist(tag);
  endtask

  logic [3:0] shoe1[$];
  logic [3:0] exp_vals [13];
  int ndiff;

  initial begin
    reset = 1'b1; draw_req = 1'b0; shuffle_req = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(card_valid), 0);
    chk("rst_rank",  int'(card_rank), 0);
    chk("rst_left",  int'(cards_left), 0);
    chk("rst_shuf",  int'(shuffling), 1);
    chk("rst_ready", int'(draw_ready), 0);
    tick(); reset = 1'b0;

    // Requests while shuffling are ignored, not queued
    draw_req = 1'b1; shuffle_req = 1'b1;
    tick();
    chk("model_lfsr_step1", int'(m_lfsr), 32'h0000E270);
    for (int t = 2; t <= 52; t++) begin
      if (t == 20) shuffle_req = 1'b0;
      tick();
      if (t == 51) begin
        @(negedge clk);
        chk("ready_t51", int'(draw_ready), 0);
      end
    end
    @(negedge clk);
`ifdef DEALER_FIXED_DECK_EN
    chk("ready_t52", int'(draw_ready), 1);
`else
    chk("ready_t52", int'(draw_ready), 0);
`endif
    draw_req = 1'b0;
    wait_ready("first");
    chk("first_left_full", int'(cards_left), 52);
    chk("no_card_while_shuffling", q.size(), 0);

    deal_full_shoe("shoe1");
    shoe1 = q;
    ndiff = 0;
    for (int k = 0; k < N && k < shoe1.size(); k++) if (shoe1[k] != 4'((k % 13) + 1)) ndiff++;
`ifdef DEALER_FIXED_DECK_EN
    chk("shoe1_fill_order", ndiff, 0);
    exp_vals = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd10, 4'd10, 4'd10};
    for (int k = 0; k < 13 && k < qv.size(); k++) begin
      chk($sformatf("fixed_value%0d", k), int'(qv[k]), int'(exp_vals[k]));
      chk($sformatf("fixed_rank%0d", k), int'(shoe1[k]), k + 1);
    end
`else
    chk("shoe1_shuffled", int'(ndiff > 0), 1);
`endif

    // Second shoe dealt with gaps in the request stream
    wait_ready("shoe2");
    chk("shoe2_left_full", int'(cards_left), 52);
    q.delete(); qv.delete();
    for (int j = 0; j < 400 && q.size() < 52; j++) begin
      tick();
      draw_req = (j % 3 != 2);
    end
    draw_req = 1'b0;
    tick();
    @(negedge clk);
    check_hist("shoe2");
    ndiff = 0;
    for (int k = 0; k < N && k < q.size() && k < shoe1.size(); k++) if (q[k] != shoe1[k]) ndiff++;
`ifdef DEALER_FIXED_DECK_EN
    chk("shoe2_same_as_shoe1", ndiff, 0);
`else
    chk("shoe2_differs", int'(ndiff > 0), 1);
`endif

    // shuffle_req and draw_req together in IDLE: shuffle wins
    wait_ready("both");
    q.delete(); qv.delete();
    tick(); draw_req = 1'b1;
    repeat (5) tick();
    shuffle_req = 1'b1;
    @(negedge clk);
    chk("both_ready_low", int'(draw_ready), 0);
    tick(); shuffle_req = 1'b0; draw_req = 1'b0;
    @(negedge clk);
    chk("both_no_valid", int'(card_valid), 0);
    chk("both_left_zero", int'(cards_left), 0);
    chk("both_shuffling", int'(shuffling), 1);
    chk("both_cards_dealt", q.size(), 5);

    // Asynchronous reset in the middle of the shuffle
    repeat (60) tick();
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", int'(card_valid), 0);
    chk("midrst_rank",  int'(card_rank), 0);
    chk("midrst_value", int'(card_value), 0);
    chk("midrst_left",  int'(cards_left), 0);
    chk("midrst_shuf",  int'(shuffling), 1);
    chk("midrst_ready", int'(draw_ready), 0);
    tick(); tick(); reset = 1'b0;
    wait_ready("midrst");
    chk("midrst_left_full", int'(cards_left), 52);
    deal_full_shoe("shoe3");

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
